// File: rtl/group_update_sequencer_if.sv
// Handshake and group-select bundle between the factorization controller
// (master) and the group update sequencer (slave).
interface group_update_sequencer_if #(
  parameter int SWEEP_W = 16
);
  logic               start;
  logic               stop;
  logic               pause;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [2:0]         group_en;
  logic               group_valid;
  logic               busy;
  logic               done;
  logic               sweep_end;
  logic [SWEEP_W-1:0] sweep_cnt;

  modport master (
    output start, stop, pause, num_sweeps,
    input  group_en, group_valid, busy, done, sweep_end, sweep_cnt
  );

  modport slave (
    input  start, stop, pause, num_sweeps,
    output group_en, group_valid, busy, done, sweep_end, sweep_cnt
  );
endinterface

// File: rtl/group_update_sequencer.sv
// Steps the p-bit update-order LUT through colour groups with hold/gap timing.
// Optional GRPSEQ_RANDOM_START_EN: LFSR-chosen start group per sweep.
module group_update_sequencer #(
  parameter int NUM_GROUPS  = 5,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int SWEEP_W     = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  group_update_sequencer_if.slave bus_if
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP, DONE} state_e;

  localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LAST_I);
  localparam logic [2:0]       LAST_GROUP = 3'(NUM_GROUPS - 1);
  localparam bit               NO_GAP     = (GAP_CYCLES == 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         group_q, group_d;
  logic [2:0]         startGrp_q, startGrp_d;
  logic [SWEEP_W-1:0] sweepCnt_q, sweepCnt_d;
  logic [SWEEP_W-1:0] numSweeps_q, numSweeps_d;

  logic [2:0]         groupNext;
  logic [2:0]         startGrpNext;
  logic               lastGroup;
  logic               holdLast;
  logic               groupEnd;
  logic [SWEEP_W-1:0] sweepCntInc;

`ifdef GRPSEQ_RANDOM_START_EN
  logic [7:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign startGrpNext = 3'(lfsr_q % 8'(NUM_GROUPS));
`else
  assign startGrpNext = 3'd0;
`endif

  // A sweep ends on the group just before the one it started from.
  assign groupNext   = (group_q == LAST_GROUP) ? 3'd0 : group_q + 3'd1;
  assign lastGroup   = (groupNext == startGrp_q);
  assign holdLast    = (state_q == HOLD) && (cnt_q == HOLD_LAST);
  assign groupEnd    = !bus_if.stop && !bus_if.pause &&
                       ((holdLast && NO_GAP) || ((state_q == GAP) && (cnt_q == GAP_LAST)));
  assign sweepCntInc = (&sweepCnt_q) ? sweepCnt_q : sweepCnt_q + SWEEP_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    group_d     = group_q;
    startGrp_d  = startGrp_q;
    sweepCnt_d  = sweepCnt_q;
    numSweeps_d = numSweeps_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.start && !bus_if.stop) begin
          state_d     = HOLD;
          cnt_d       = '0;
          group_d     = startGrpNext;
          startGrp_d  = startGrpNext;
          sweepCnt_d  = '0;
          numSweeps_d = bus_if.num_sweeps;
        end
      end
      HOLD, GAP: begin
        if (bus_if.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          group_d = 3'd0;
        end else if (!bus_if.pause) begin
          if (groupEnd) begin
            cnt_d = '0;
            if (!lastGroup) begin
              group_d = groupNext;
              state_d = HOLD;
            end else begin
              sweepCnt_d = sweepCntInc;
              if ((numSweeps_q != '0) && (sweepCntInc == numSweeps_q)) begin
                state_d = DONE;
              end else begin
                group_d    = startGrpNext;
                startGrp_d = startGrpNext;
                state_d    = HOLD;
              end
            end
          end else if (holdLast) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        group_d = 3'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      group_q     <= 3'd0;
      startGrp_q  <= 3'd0;
      sweepCnt_q  <= '0;
      numSweeps_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      group_q     <= group_d;
      startGrp_q  <= startGrp_d;
      sweepCnt_q  <= sweepCnt_d;
      numSweeps_q <= numSweeps_d;
    end
  end

  // Pause suppresses the current cycle's valid so frozen cycles are never applied.
  assign bus_if.group_en    = group_q;
  assign bus_if.group_valid = (state_q == HOLD) && !bus_if.pause;
  assign bus_if.busy        = (state_q == HOLD) || (state_q == GAP);
  assign bus_if.done        = (state_q == DONE);
  assign bus_if.sweep_end   = groupEnd && lastGroup;
  assign bus_if.sweep_cnt   = sweepCnt_q;

endmodule

// File: tb/tb_group_update_sequencer.sv
// Directed bench for group_update_sequencer: default build plus a GAP_CYCLES=0
// instance, with a scoreboard of expected (cycle, group) valid slots.
module tb_group_update_sequencer;

  localparam int NG = 5;
  localparam int H  = 2;
  localparam int G  = 1;
  localparam int SW = 16;
  localparam int PA = NG * (H + G);
  localparam int PB = NG * H;

  typedef struct {
    int cyc;
    int grp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   validCntA = 0;
  int   c0;
  exp_t qA[$];
  exp_t qB[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  group_update_sequencer_if #(.SWEEP_W(SW)) ifA ();
  group_update_sequencer_if #(.SWEEP_W(SW)) ifB ();

  group_update_sequencer #(
    .NUM_GROUPS(NG), .HOLD_CYCLES(H), .GAP_CYCLES(G), .SWEEP_W(SW)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .bus_if(ifA)
  );

  group_update_sequencer #(
    .NUM_GROUPS(NG), .HOLD_CYCLES(H), .GAP_CYCLES(0), .SWEEP_W(SW)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .bus_if(ifB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic st, input logic sp,
                               input logic pa, input logic [SW-1:0] n);
    if (toB) begin
      ifB.start = st; ifB.stop = sp; ifB.pause = pa; ifB.num_sweeps = n;
      ifA.start = 1'b0; ifA.stop = 1'b0; ifA.pause = 1'b0;
    end else begin
      ifA.start = st; ifA.stop = sp; ifA.pause = pa; ifA.num_sweeps = n;
      ifB.start = 1'b0; ifB.stop = 1'b0; ifB.pause = 1'b0;
    end
  endtask

  // Expected valid slots for sweeps launched by a start in cycle c0.
  task automatic pushSchedule(input bit toB, input int start, input int sweeps, input int gap);
    exp_t e;
    for (int s = 0; s < sweeps; s++)
      for (int g = 0; g < NG; g++)
        for (int h = 0; h < H; h++) begin
          e.cyc = start + 1 + s * NG * (H + gap) + g * (H + gap) + h;
          e.grp = g;
          if (toB) qB.push_back(e); else qA.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifA.group_valid === 1'b1) begin
      validCntA++;
      checkOutput("A valid expected", 32'(qA.size() != 0), 32'd1);
      if (qA.size() != 0) begin
        e = qA.pop_front();
        checkOutput("A valid cycle", cyc, e.cyc);
        checkOutput("A group_en", 32'(ifA.group_en), e.grp);
      end
    end
    if (rst_n && ifB.group_valid === 1'b1) begin
      checkOutput("B valid expected", 32'(qB.size() != 0), 32'd1);
      if (qB.size() != 0) begin
        e = qB.pop_front();
        checkOutput("B valid cycle", cyc, e.cyc);
        checkOutput("B group_en", 32'(ifB.group_en), e.grp);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    ifB.num_sweeps = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset group_en", 32'(ifA.group_en), 0);
    checkOutput("reset group_valid", 32'(ifA.group_valid), 0);
    checkOutput("reset busy", 32'(ifA.busy), 0);
    checkOutput("reset done", 32'(ifA.done), 0);
    checkOutput("reset sweep_end", 32'(ifA.sweep_end), 0);
    checkOutput("reset sweep_cnt", 32'(ifA.sweep_cnt), 0);
    checkOutput("reset B busy", 32'(ifB.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One sweep; a second start mid-run must be ignored.
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    pushSchedule(1'b0, c0, 1, G);
    for (int r = 0; r <= 18; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
        applyStimulus(1'b0, r == 5, 1'b0, 1'b0, (r == 5) ? 16'd3 : 16'd1);
      end
      @(negedge clk);
      checkOutput("T1 busy", 32'(ifA.busy), 32'(r >= 1 && r <= PA));
      checkOutput("T1 sweep_end", 32'(ifA.sweep_end), 32'(r == PA));
      checkOutput("T1 done", 32'(ifA.done), 32'(r == PA + 1));
    end
    checkOutput("T1 sweep_cnt", 32'(ifA.sweep_cnt), 1);
    checkOutput("T1 group_en idle", 32'(ifA.group_en), 0);
    checkOutput("T1 queue drained", qA.size(), 0);

    // GAP_CYCLES=0 instance, three sweeps back to back.
    @(posedge clk); #1;
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'd3);
    pushSchedule(1'b1, c0, 3, 0);
    for (int r = 0; r <= 33; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
      end
      @(negedge clk);
      checkOutput("T2 valid", 32'(ifB.group_valid), 32'(r >= 1 && r <= 3 * PB));
      checkOutput("T2 busy", 32'(ifB.busy), 32'(r >= 1 && r <= 3 * PB));
      checkOutput("T2 sweep_end", 32'(ifB.sweep_end), 32'(r > 0 && r <= 3 * PB && r % PB == 0));
      checkOutput("T2 done", 32'(ifB.done), 32'(r == 3 * PB + 1));
    end
    checkOutput("T2 sweep_cnt", 32'(ifB.sweep_cnt), 3);
    checkOutput("T2 queue drained", qB.size(), 0);

    // Pause for four cycles over the second g2 hold cycle.
    @(posedge clk); #1;
    c0 = cyc;
    validCntA = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    pushSchedule(1'b0, c0, 1, G);
    foreach (qA[i]) if (qA[i].cyc >= c0 + 8) qA[i].cyc += 4;
    for (int r = 0; r <= 22; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, r >= 8 && r <= 11, 16'd1);
      end
      @(negedge clk);
      if (r >= 8 && r <= 11) checkOutput("T3 valid paused", 32'(ifA.group_valid), 0);
      checkOutput("T3 sweep_end", 32'(ifA.sweep_end), 32'(r == PA + 4));
      checkOutput("T3 done", 32'(ifA.done), 32'(r == PA + 5));
    end
    checkOutput("T3 valid count", validCntA, 2 * NG);
    checkOutput("T3 queue drained", qA.size(), 0);

    // Endless run stopped in the second g1 hold cycle of sweep eight.
    @(posedge clk); #1;
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    pushSchedule(1'b0, c0, 8, G);
    while (qA.size() != 0 && qA[$].cyc > c0 + 7 * PA + 5) void'(qA.pop_back());
    for (int r = 0; r <= 7 * PA + 7; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, r == 7 * PA + 5, 1'b0, 16'd0);
      end
      @(negedge clk);
      checkOutput("T4 done", 32'(ifA.done), 0);
      checkOutput("T4 sweep_end", 32'(ifA.sweep_end), 32'(r > 0 && r <= 7 * PA && r % PA == 0));
      if (r == PA + 1) checkOutput("T4 sweep_cnt 1", 32'(ifA.sweep_cnt), 1);
      if (r >= 7 * PA + 6) begin
        checkOutput("T4 stop busy", 32'(ifA.busy), 0);
        checkOutput("T4 stop valid", 32'(ifA.group_valid), 0);
        checkOutput("T4 stop sweep_cnt", 32'(ifA.sweep_cnt), 7);
        checkOutput("T4 stop group_en", 32'(ifA.group_en), 0);
      end
    end
    checkOutput("T4 queue drained", qA.size(), 0);

    // Async reset while holding g3, then start+stop together in IDLE.
    @(posedge clk); #1;
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    pushSchedule(1'b0, c0, 1, G);
    for (int r = 1; r <= 9; r++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    end
    @(posedge clk); #1;
    checkOutput("T5 pre-reset group_en", 32'(ifA.group_en), 3);
    checkOutput("T5 pre-reset valid", 32'(ifA.group_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("T5 reset group_en", 32'(ifA.group_en), 0);
    checkOutput("T5 reset valid", 32'(ifA.group_valid), 0);
    checkOutput("T5 reset busy", 32'(ifA.busy), 0);
    checkOutput("T5 reset sweep_end", 32'(ifA.sweep_end), 0);
    checkOutput("T5 reset done", 32'(ifA.done), 0);
    qA.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
    @(negedge clk);
    checkOutput("T5 start+stop busy now", 32'(ifA.busy), 0);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
      @(negedge clk);
      checkOutput("T5 start+stop busy", 32'(ifA.busy), 0);
      checkOutput("T5 start+stop valid", 32'(ifA.group_valid), 0);
      checkOutput("T5 start+stop done", 32'(ifA.done), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
